riscv_retire_checker: RTL and testbench

//  Synthesizable self-check stage downstream of RISCV_TOP. Watches NUM_INST,

---
 rtl/riscv_retire_checker.sv | 155 +++++++++++++++
 tb/tb_riscv_retire_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_retire_checker.sv
// rtl/riscv_retire_checker.sv - retire-stream self-check against a programmable (inst, ans) table
module riscv_retire_checker #(
  parameter int NUM_TEST = 32,
  parameter int AW       = 5,
  parameter int TIMEOUT  = 100000
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          CFG_WE,
  input  logic [AW-1:0] CFG_ADDR,
  input  logic [31:0]   CFG_INST,
  input  logic [31:0]   CFG_ANS,
  input  logic [AW:0]   TEST_CNT,
  input  logic          START,
  input  logic          CLEAR,
  input  logic [31:0]   NUM_INST,
  input  logic [31:0]   OUTPUT_PORT,
  input  logic          HALT,
  output logic [2:0]    STATUS,
  output logic          DONE,
  output logic [AW:0]   PASS_CNT,
  output logic [AW-1:0] FAIL_IDX,
  output logic [31:0]   FAIL_VAL,
  output logic [31:0]   CYCLES
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_PASS     = 3'd2,
    S_MISMATCH = 3'd3,
    S_MISSED   = 3'd4,
    S_EARLY    = 3'd5,
    S_TIMEOUT  = 3'd6
  } state_t;

  localparam logic [AW:0] NT      = (AW+1)'(NUM_TEST);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  // Expected-value table; deliberately not reset so it survives a core reset.
  logic [31:0] inst_tab [NUM_TEST];
  logic [31:0] ans_tab  [NUM_TEST];

  state_t      state;
  logic [AW:0] test_cnt_r;
  logic [AW-1:0] idx;
  logic [31:0] timer;

  logic [31:0] e_inst;
  logic [31:0] e_ans;
  logic [AW:0] idx_next;
  logic        is_last;
  logic [AW:0] tc_clamped;
  logic        addr_ok;

  assign e_inst     = inst_tab[idx];
  assign e_ans      = ans_tab[idx];
  assign idx_next   = {1'b0, idx} + (AW+1)'(1);
  assign is_last    = (idx_next == test_cnt_r);
  assign tc_clamped = (TEST_CNT > NT) ? NT : TEST_CNT;
  assign addr_ok    = ({1'b0, CFG_ADDR} < NT);
  assign STATUS     = state;

  // Table writes are only accepted while idle so a running check sees a stable table.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && CFG_WE && addr_ok) begin
      inst_tab[CFG_ADDR] <= CFG_INST;
      ans_tab[CFG_ADDR]  <= CFG_ANS;
    end
  end

  // Check FSM: state register doubles as STATUS; all result outputs registered here.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      DONE       <= 1'b0;
      PASS_CNT   <= '0;
      FAIL_IDX   <= '0;
      FAIL_VAL   <= '0;
      CYCLES     <= '0;
      test_cnt_r <= '0;
      idx        <= '0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            test_cnt_r <= tc_clamped;
            idx        <= '0;
            PASS_CNT   <= '0;
            CYCLES     <= '0;
            timer      <= '0;
            if (tc_clamped == '0) begin
              state <= S_PASS;
              DONE  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (CYCLES != 32'hFFFF_FFFF) CYCLES <= CYCLES + 32'd1;
          if (NUM_INST == e_inst) begin
            if (OUTPUT_PORT == e_ans) begin
              PASS_CNT <= PASS_CNT + (AW+1)'(1);
              idx      <= idx + 1'b1;
              timer    <= '0;
              if (is_last) begin
                state <= S_PASS;
                DONE  <= 1'b1;
              end else if (HALT) begin
                // Core stopped with entries still pending: blame the next one.
                state    <= S_EARLY;
                DONE     <= 1'b1;
                FAIL_IDX <= idx + 1'b1;
                FAIL_VAL <= OUTPUT_PORT;
              end
            end else begin
              state    <= S_MISMATCH;
              DONE     <= 1'b1;
              FAIL_IDX <= idx;
              FAIL_VAL <= OUTPUT_PORT;
            end
          end else if (NUM_INST > e_inst) begin
            // Also catches non-increasing table entries instead of hanging.
            state    <= S_MISSED;
            DONE     <= 1'b1;
            FAIL_IDX <= idx;
            FAIL_VAL <= OUTPUT_PORT;
          end else if (HALT) begin
            state    <= S_EARLY;
            DONE     <= 1'b1;
            FAIL_IDX <= idx;
            FAIL_VAL <= OUTPUT_PORT;
          end else if (timer == TO_LAST) begin
            state    <= S_TIMEOUT;
            DONE     <= 1'b1;
            FAIL_IDX <= idx;
            FAIL_VAL <= OUTPUT_PORT;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: begin
          // Terminal states hold results until software acknowledges with CLEAR.
          if (CLEAR) begin
            state <= S_IDLE;
            DONE  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_retire_checker.sv
// tb/tb_riscv_retire_checker.sv - directed self-checking bench for riscv_retire_checker
module tb_riscv_retire_checker;

  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          CFG_WE;
  logic [AW-1:0] CFG_ADDR;
  logic [31:0]   CFG_INST;
  logic [31:0]   CFG_ANS;
  logic [AW:0]   TEST_CNT;
  logic          START;
  logic          CLEAR;
  logic [31:0]   NUM_INST;
  logic [31:0]   OUTPUT_PORT;
  logic          HALT;
  logic [2:0]    STATUS;
  logic          DONE;
  logic [AW:0]   PASS_CNT;
  logic [AW-1:0] FAIL_IDX;
  logic [31:0]   FAIL_VAL;
  logic [31:0]   CYCLES;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ans [21];

  riscv_retire_checker #(.NUM_TEST(32), .AW(AW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_INST(CFG_INST), .CFG_ANS(CFG_ANS),
    .TEST_CNT(TEST_CNT), .START(START), .CLEAR(CLEAR),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
    .STATUS(STATUS), .DONE(DONE), .PASS_CNT(PASS_CNT),
    .FAIL_IDX(FAIL_IDX), .FAIL_VAL(FAIL_VAL), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle 1ns past it for both driving and sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] inst, input logic [31:0] ans);
    CFG_WE = 1'b1; CFG_ADDR = AW'(a); CFG_INST = inst; CFG_ANS = ans;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic start(input int cnt);
    TEST_CNT = (AW+1)'(cnt); START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  // Retire entries first..last (1-based inst numbers) with correct answers.
  task automatic retire(input int first, input int last, input bit halt_last);
    for (int k = first; k <= last; k++) begin
      NUM_INST = 32'(k); OUTPUT_PORT = exp_ans[k-1];
      HALT = halt_last && (k == last);
      tick();
    end
    HALT = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_INST = '0; CFG_ANS = '0;
    TEST_CNT = '0; START = 1'b0; CLEAR = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
    tick(); tick();
    chk("rst_status", 32'(STATUS), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_pass", 32'(PASS_CNT), 0);
    chk("rst_fidx", 32'(FAIL_IDX), 0);
    chk("rst_fval", FAIL_VAL, 0);
    chk("rst_cyc", CYCLES, 0);
    RSTn = 1'b1;

    for (int k = 0; k < 21; k++) begin
      exp_ans[k] = 32'hA000_0000 + 32'(k * 7);
      wr(k, 32'(k + 1), exp_ans[k]);
    end

    // T1: full 21-entry run, HALT with the last retire
    start(21);
    chk("t1_run", 32'(STATUS), 1);
    retire(1, 21, 1'b1);
    chk("t1_status", 32'(STATUS), 2);
    chk("t1_pass", 32'(PASS_CNT), 21);
    chk("t1_done", 32'(DONE), 1);
    chk("t1_cyc", CYCLES, 21);
    start(21);
    chk("t1_start_ign", 32'(STATUS), 2);
    clear();
    chk("t1_clr", 32'(STATUS), 0);
    chk("t1_keep_pass", 32'(PASS_CNT), 21);

    // T2: entry 3 expects 1, core outputs 0
    exp_ans[2] = 32'd1;
    wr(2, 32'd3, 32'd1);
    start(21);
    retire(1, 2, 1'b0);
    NUM_INST = 32'd3; OUTPUT_PORT = 32'd0;
    tick();
    chk("t2_status", 32'(STATUS), 3);
    chk("t2_fidx", 32'(FAIL_IDX), 2);
    chk("t2_fval", FAIL_VAL, 0);
    chk("t2_pass", 32'(PASS_CNT), 2);
    chk("t2_cyc", CYCLES, 3);
    clear();

    // T3: NUM_INST skips 5
    start(21);
    retire(1, 4, 1'b0);
    NUM_INST = 32'd6; OUTPUT_PORT = 32'hDEAD_BEEF;
    tick();
    chk("t3_status", 32'(STATUS), 4);
    chk("t3_fidx", 32'(FAIL_IDX), 4);
    chk("t3_fval", FAIL_VAL, 32'hDEAD_BEEF);
    chk("t3_pass", 32'(PASS_CNT), 4);
    clear();

    // T4: early halt, then halt with final match, then mismatch with halt
    start(21);
    retire(1, 10, 1'b1);
    chk("t4_early", 32'(STATUS), 5);
    chk("t4_pass", 32'(PASS_CNT), 10);
    clear();
    start(3);
    retire(1, 3, 1'b1);
    chk("t4_final_halt", 32'(STATUS), 2);
    chk("t4_final_pass", 32'(PASS_CNT), 3);
    clear();
    start(21);
    NUM_INST = 32'd1; OUTPUT_PORT = 32'h1234_5678; HALT = 1'b1;
    tick();
    HALT = 1'b0;
    chk("t4_mm_halt", 32'(STATUS), 3);
    chk("t4_mm_fidx", 32'(FAIL_IDX), 0);
    chk("t4_mm_fval", FAIL_VAL, 32'h1234_5678);
    clear();

    // T5: NUM_INST stuck below entry 0 -> timeout after 16 RUN cycles
    NUM_INST = 32'd0; OUTPUT_PORT = 32'd0;
    start(21);
    for (int i = 0; i < 15; i++) tick();
    chk("t5_still_run", 32'(STATUS), 1);
    tick();
    chk("t5_status", 32'(STATUS), 6);
    chk("t5_cyc", CYCLES, 16);
    chk("t5_done", 32'(DONE), 1);
    tick();
    chk("t5_frozen", CYCLES, 16);
    clear();

    // T6: reset mid-run, rerun with retained table, zero-entry start
    start(21);
    retire(1, 5, 1'b0);
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    chk("t6_rst_status", 32'(STATUS), 0);
    chk("t6_rst_pass", 32'(PASS_CNT), 0);
    clear();
    chk("t6_clr_idle", 32'(STATUS), 0);
    exp_ans[0] = 32'h55;
    CFG_WE = 1'b1; CFG_ADDR = '0; CFG_INST = 32'd1; CFG_ANS = 32'h55;
    start(21);
    CFG_WE = 1'b0;
    retire(1, 21, 1'b0);
    chk("t6_rerun", 32'(STATUS), 2);
    chk("t6_rerun_pass", 32'(PASS_CNT), 21);
    clear();
    start(0);
    chk("t6_zero", 32'(STATUS), 2);
    chk("t6_zero_done", 32'(DONE), 1);
    chk("t6_zero_pass", 32'(PASS_CNT), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
